// File: rtl/pwm_pkg.sv
// Shared types and constants for the PWM capture path.
package pwm_pkg;

  typedef enum logic [1:0] {
    ACQUIRE = 2'd0,
    HIGH    = 2'd1,
    LOW     = 2'd2
  } pwm_state_e;

  localparam int DUTY_W   = 8;
  localparam int DUTY_MAX = 255;

  // High time clamped into the 8-bit duty code used by pwm_generator.
  function automatic logic [DUTY_W-1:0] sat_duty(input logic [31:0] cnt);
    if (cnt > 32'(DUTY_MAX)) begin
      return DUTY_W'(DUTY_MAX);
    end
    return cnt[DUTY_W-1:0];
  endfunction

endpackage

// File: rtl/pwm_sync_edge.sv
// Synchroniser chain for the asynchronous PWM line plus single-cycle edge pulses.
module pwm_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic pwm_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   dly_q;

  // Shift the raw line through the synchroniser and keep a one-cycle delayed copy.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
      dly_q  <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pwm_i};
      dly_q  <= sync_q[SYNC_STAGES-1];
    end
  end

  assign level_o = sync_q[SYNC_STAGES-1];
  assign rise_o  = level_o & ~dly_q;
  assign fall_o  = ~level_o & dly_q;

endmodule

// File: rtl/pwm_capture.sv
// Measures high time and period of an incoming PWM waveform, derives the duty
// code and flags a stuck line when no edge arrives for TIMEOUT cycles.
//
// state   | meaning
// ACQUIRE | waiting for a first rise; no complete period available yet
// HIGH    | line high, high and period counters running
// LOW     | line low, only the period counter running; next rise publishes
module pwm_capture #(
  parameter int CNT_W       = 16,
  parameter int TIMEOUT     = 1024,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             pwm_in,
  output logic [7:0]       duty_out,
  output logic [CNT_W-1:0] high_out,
  output logic [CNT_W-1:0] period_out,
  output logic             valid,
  output logic             locked,
  output logic             stuck
);

  import pwm_pkg::*;

  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

  logic level, rise, fall, edge_det, timeout_evt;

  pwm_state_e       state_q, state_d;
  logic [CNT_W-1:0] per_cnt_q, per_cnt_d;
  logic [CNT_W-1:0] high_cnt_q, high_cnt_d;
  logic [CNT_W-1:0] idle_cnt_q, idle_cnt_d;
  logic [CNT_W-1:0] high_out_q, high_out_d;
  logic [CNT_W-1:0] period_out_q, period_out_d;
  logic [DUTY_W-1:0] duty_q, duty_d;
  logic             valid_q, valid_d;
  logic             locked_q, locked_d;
  logic             stuck_q, stuck_d;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_ONE;
  endfunction

  pwm_sync_edge #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk    (clk),
    .reset_n(reset_n),
    .pwm_i  (pwm_in),
    .level_o(level),
    .rise_o (rise),
    .fall_o (fall)
  );

  assign edge_det = rise | fall;

  // Next-state: measurement FSM, counters, timeout and publish of results.
  always_comb begin
    state_d      = state_q;
    per_cnt_d    = per_cnt_q;
    high_cnt_d   = high_cnt_q;
    idle_cnt_d   = idle_cnt_q;
    high_out_d   = high_out_q;
    period_out_d = period_out_q;
    duty_d       = duty_q;
    valid_d      = 1'b0;
    locked_d     = locked_q;
    stuck_d      = stuck_q;
    timeout_evt  = 1'b0;

    if (!enable) begin
      state_d    = ACQUIRE;
      per_cnt_d  = '0;
      high_cnt_d = '0;
      idle_cnt_d = '0;
      locked_d   = 1'b0;
      stuck_d    = 1'b0;
    end else begin
      // idle_cnt parks at TIMEOUT so a stuck line reports only once
      if (edge_det) begin
        idle_cnt_d = '0;
        stuck_d    = 1'b0;
      end else if (idle_cnt_q != TIMEOUT_C) begin
        idle_cnt_d  = idle_cnt_q + CNT_ONE;
        timeout_evt = (idle_cnt_q == TIMEOUT_C - CNT_ONE);
      end

      if (timeout_evt) begin
        state_d      = ACQUIRE;
        stuck_d      = 1'b1;
        locked_d     = 1'b0;
        period_out_d = '0;
        high_out_d   = '0;
        duty_d       = level ? DUTY_W'(DUTY_MAX) : '0;
        valid_d      = 1'b1;
      end else begin
        unique case (state_q)
          ACQUIRE: begin
            if (rise) begin
              state_d    = HIGH;
              per_cnt_d  = CNT_ONE;
              high_cnt_d = CNT_ONE;
            end
          end
          HIGH: begin
            if (rise) begin
              per_cnt_d  = CNT_ONE;
              high_cnt_d = CNT_ONE;
            end else if (fall) begin
              state_d   = LOW;
              per_cnt_d = sat_inc(per_cnt_q);
            end else begin
              per_cnt_d  = sat_inc(per_cnt_q);
              high_cnt_d = sat_inc(high_cnt_q);
            end
          end
          LOW: begin
            if (rise) begin
              state_d      = HIGH;
              high_out_d   = high_cnt_q;
              period_out_d = per_cnt_q;
              duty_d       = sat_duty(32'(high_cnt_q));
              valid_d      = 1'b1;
              locked_d     = 1'b1;
              stuck_d      = 1'b0;
              per_cnt_d    = CNT_ONE;
              high_cnt_d   = CNT_ONE;
            end else begin
              per_cnt_d = sat_inc(per_cnt_q);
            end
          end
          default: state_d = ACQUIRE;
        endcase
      end
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ACQUIRE;
      per_cnt_q    <= '0;
      high_cnt_q   <= '0;
      idle_cnt_q   <= '0;
      high_out_q   <= '0;
      period_out_q <= '0;
      duty_q       <= '0;
      valid_q      <= 1'b0;
      locked_q     <= 1'b0;
      stuck_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      per_cnt_q    <= per_cnt_d;
      high_cnt_q   <= high_cnt_d;
      idle_cnt_q   <= idle_cnt_d;
      high_out_q   <= high_out_d;
      period_out_q <= period_out_d;
      duty_q       <= duty_d;
      valid_q      <= valid_d;
      locked_q     <= locked_d;
      stuck_q      <= stuck_d;
    end
  end

  assign duty_out   = duty_q;
  assign high_out   = high_out_q;
  assign period_out = period_out_q;
  assign valid      = valid_q;
  assign locked     = locked_q;
  assign stuck      = stuck_q;

endmodule

// File: tb/tb_pwm_capture.sv
// Directed bench for pwm_capture: square waves, saturation, stuck line,
// reset and enable interruptions.
module tb_pwm_capture;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        enable;
  logic        pwm_in;
  logic [7:0]  duty_out;
  logic [15:0] high_out;
  logic [15:0] period_out;
  logic        valid;
  logic        locked;
  logic        stuck;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int vcnt = 0;
  int last_v = 0;
  int gap = 0;
  int v0;

  pwm_capture #(
    .CNT_W(16),
    .TIMEOUT(1024),
    .SYNC_STAGES(2)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .enable    (enable),
    .pwm_in    (pwm_in),
    .duty_out  (duty_out),
    .high_out  (high_out),
    .period_out(period_out),
    .valid     (valid),
    .locked    (locked),
    .stuck     (stuck)
  );

  always #5 clk = ~clk;

  // Count valid cycles and the spacing between consecutive pulses.
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (valid === 1'b1) begin
      vcnt   = vcnt + 1;
      gap    = cyc - last_v;
      last_v = cyc;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic hold(input logic lvl, input int n);
    pwm_in = lvl;
    repeat (n) @(negedge clk);
  endtask

  task automatic square(input int hi, input int lo, input int nper);
    for (int i = 0; i < nper; i++) begin
      hold(1'b1, hi);
      hold(1'b0, lo);
    end
  endtask

  initial begin
    reset_n = 1'b0;
    enable  = 1'b1;
    pwm_in  = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_duty",   32'(duty_out),   0);
    chk("rst_high",   32'(high_out),   0);
    chk("rst_period", 32'(period_out), 0);
    chk("rst_valid",  32'(valid),      0);
    chk("rst_locked", 32'(locked),     0);
    chk("rst_stuck",  32'(stuck),      0);
    reset_n = 1'b1;
    hold(1'b0, 10);

    // 64 high / 192 low
    v0 = vcnt;
    square(64, 192, 4);
    chk("sq64_vcnt",   32'(vcnt - v0),  3);
    chk("sq64_gap",    32'(gap),        256);
    chk("sq64_duty",   32'(duty_out),   64);
    chk("sq64_high",   32'(high_out),   64);
    chk("sq64_period", 32'(period_out), 256);
    chk("sq64_locked", 32'(locked),     1);
    chk("sq64_stuck",  32'(stuck),      0);

    // 255 high / 1 low; first rise publishes the pending 64/192 period
    v0 = vcnt;
    square(255, 1, 3);
    chk("d255_vcnt",   32'(vcnt - v0),  3);
    chk("d255_duty",   32'(duty_out),   255);
    chk("d255_high",   32'(high_out),   255);
    chk("d255_period", 32'(period_out), 256);

    // line stuck low
    v0 = vcnt;
    hold(1'b0, 1100);
    chk("stk0_vcnt",   32'(vcnt - v0),  1);
    chk("stk0_stuck",  32'(stuck),      1);
    chk("stk0_duty",   32'(duty_out),   0);
    chk("stk0_high",   32'(high_out),   0);
    chk("stk0_period", 32'(period_out), 0);
    chk("stk0_locked", 32'(locked),     0);

    // rise clears stuck, then line stuck high
    v0 = vcnt;
    hold(1'b1, 5);
    chk("stk_clear",   32'(stuck),      0);
    chk("stk_clr_v",   32'(vcnt - v0),  0);
    hold(1'b1, 1095);
    chk("stk1_vcnt",   32'(vcnt - v0),  1);
    chk("stk1_stuck",  32'(stuck),      1);
    chk("stk1_duty",   32'(duty_out),   255);
    chk("stk1_period", 32'(period_out), 0);
    chk("stk1_locked", 32'(locked),     0);

    // 300 high / 100 low: duty saturates
    hold(1'b0, 10);
    chk("fall_clear",  32'(stuck),      0);
    v0 = vcnt;
    square(300, 100, 3);
    chk("s300_vcnt",   32'(vcnt - v0),  2);
    chk("s300_gap",    32'(gap),        400);
    chk("s300_high",   32'(high_out),   300);
    chk("s300_duty",   32'(duty_out),   255);
    chk("s300_period", 32'(period_out), 400);
    chk("s300_locked", 32'(locked),     1);

    // reset asserted in the middle of a high phase
    hold(1'b1, 100);
    reset_n = 1'b0;
    #1;
    chk("mrst_duty",   32'(duty_out),   0);
    chk("mrst_high",   32'(high_out),   0);
    chk("mrst_period", 32'(period_out), 0);
    chk("mrst_locked", 32'(locked),     0);
    chk("mrst_valid",  32'(valid),      0);
    @(negedge clk);
    pwm_in = 1'b0;
    repeat (5) @(negedge clk);
    reset_n = 1'b1;
    hold(1'b0, 10);
    v0 = vcnt;
    square(100, 100, 1);
    chk("mrst_first_v", 32'(vcnt - v0), 0);
    chk("mrst_first_l", 32'(locked),    0);
    square(100, 100, 2);
    chk("mrst_vcnt",   32'(vcnt - v0),  2);
    chk("mrst_duty2",  32'(duty_out),   100);
    chk("mrst_high2",  32'(high_out),   100);
    chk("mrst_per2",   32'(period_out), 200);

    // enable dropped for 50 cycles mid-period
    hold(1'b1, 40);
    v0 = vcnt;
    enable = 1'b0;
    hold(1'b1, 5);
    chk("dis_locked",  32'(locked),     0);
    chk("dis_stuck",   32'(stuck),      0);
    chk("dis_duty",    32'(duty_out),   100);
    chk("dis_high",    32'(high_out),   100);
    chk("dis_period",  32'(period_out), 200);
    hold(1'b0, 45);
    chk("dis_vcnt",    32'(vcnt - v0),  0);
    enable = 1'b1;
    square(80, 120, 1);
    chk("ren_first_v", 32'(vcnt - v0),  0);
    chk("ren_first_l", 32'(locked),     0);
    square(80, 120, 1);
    chk("ren_vcnt",    32'(vcnt - v0),  1);
    chk("ren_duty",    32'(duty_out),   80);
    chk("ren_high",    32'(high_out),   80);
    chk("ren_period",  32'(period_out), 200);
    chk("ren_locked",  32'(locked),     1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
